// File: rtl/axi_osd_frame_sequencer.sv
// Raster sequencer for the OSD render path: walks one frame cell by cell, fetches the
// character code and glyph row, and streams fg/bg pixels out over AXI-Stream.
module axi_osd_frame_sequencer #(
  parameter int                     CONSOLE_DEPTH    = 12,
  parameter int                     FRAME_WIDTH      = 640,
  parameter int                     FRAME_HEIGHT     = 480,
  parameter int                     FONT_WIDTH       = 8,
  parameter int                     FONT_ROW_BITS    = 4,
  parameter int                     PIXEL_WIDTH      = 24,
  parameter logic [PIXEL_WIDTH-1:0] FOREGROUND_COLOR = 24'hFFFFFF,
  parameter logic [PIXEL_WIDTH-1:0] BACKGROUND_COLOR = 24'h000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_enable,
  input  logic [CONSOLE_DEPTH-1:0]      i_start_offset,
  input  logic                          i_cursor_en,
  input  logic [CONSOLE_DEPTH-1:0]      i_cursor_addr,
  output logic                          o_char_rd,
  output logic [CONSOLE_DEPTH-1:0]      o_char_addr,
  input  logic [7:0]                    i_char_data,
  output logic                          o_font_rd,
  output logic [8+FONT_ROW_BITS-1:0]    o_font_addr,
  input  logic [FONT_WIDTH-1:0]         i_font_data,
  output logic [PIXEL_WIDTH-1:0]        o_axis_data,
  output logic                          o_axis_valid,
  input  logic                          i_axis_ready,
  output logic                          o_axis_last,
  output logic [3:0]                    o_axis_user,
  output logic                          o_busy,
  output logic [15:0]                   o_frame_count
);

  localparam int COLS = FRAME_WIDTH / FONT_WIDTH;
  localparam int ROWS = FRAME_HEIGHT >> FONT_ROW_BITS;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW   = (FONT_WIDTH > 1) ? $clog2(FONT_WIDTH) : 1;
  localparam int FAW  = 8 + FONT_ROW_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CHAR_RD, S_FONT_RD, S_LOAD, S_EMIT, S_DONE
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [CONSOLE_DEPTH-1:0] r_line_base;
  logic [CONSOLE_DEPTH-1:0] r_cursor_addr;
  logic                     r_cursor_en;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_crow;
  logic [FONT_ROW_BITS-1:0] r_grow;
  logic [BW-1:0]            r_bit;
  logic [FONT_WIDTH-1:0]    r_shift;
  logic                     r_hit;
  logic                     r_busy;
  logic [15:0]              r_frame_count;
  logic [CONSOLE_DEPTH-1:0] r_char_addr;
  logic [FAW-1:0]           r_font_addr;

  logic [CONSOLE_DEPTH-1:0] w_cell_addr;
  logic [FAW-1:0]           w_font_addr;
  logic                     w_emit, w_accept;
  logic                     w_cell_end, w_line_end, w_grow_end, w_crow_end, w_frame_end;
  logic                     w_sof, w_pix;

  // Cell address = line base (start + cell_row*COLS, kept incrementally) + column.
  assign w_cell_addr = r_line_base + CONSOLE_DEPTH'(r_col);
  assign w_font_addr = {i_char_data, r_grow};

  assign w_emit      = (r_state == S_EMIT);
  assign w_accept    = w_emit && i_axis_ready;
  assign w_cell_end  = (r_bit == BW'(FONT_WIDTH - 1));
  assign w_line_end  = (r_col == CW'(COLS - 1));
  assign w_grow_end  = (r_grow == {FONT_ROW_BITS{1'b1}});
  assign w_crow_end  = (r_crow == RW'(ROWS - 1));
  assign w_frame_end = w_line_end && w_grow_end && w_crow_end;
  assign w_sof       = (r_col == '0) && (r_crow == '0) && (r_grow == '0) && (r_bit == '0);
  assign w_pix       = r_shift[FONT_WIDTH-1] ^ r_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_enable) w_state_nxt = S_CHAR_RD;
      S_CHAR_RD: w_state_nxt = S_FONT_RD;
      S_FONT_RD: w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_EMIT;
      S_EMIT:    if (w_accept && w_cell_end) w_state_nxt = w_frame_end ? S_DONE : S_CHAR_RD;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line_base   <= '0;
      r_cursor_addr <= '0;
      r_cursor_en   <= 1'b0;
      r_col         <= '0;
      r_crow        <= '0;
      r_grow        <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_hit         <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
      r_char_addr   <= '0;
      r_font_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_enable) begin
          r_line_base   <= i_start_offset;
          r_cursor_addr <= i_cursor_addr;
          r_cursor_en   <= i_cursor_en;
          r_col         <= '0;
          r_crow        <= '0;
          r_grow        <= '0;
          r_bit         <= '0;
          r_busy        <= 1'b1;
        end
        S_CHAR_RD: r_char_addr <= w_cell_addr;
        S_FONT_RD: begin
          r_font_addr <= w_font_addr;
          r_hit       <= r_cursor_en && (w_cell_addr == r_cursor_addr);
        end
        S_LOAD: r_shift <= i_font_data;
        S_EMIT: if (w_accept) begin
          r_shift <= r_shift << 1;
          if (!w_cell_end) begin
            r_bit <= r_bit + 1'b1;
          end else begin
            r_bit <= '0;
            if (!w_line_end) begin
              r_col <= r_col + 1'b1;
            end else begin
              r_col <= '0;
              // Line base only advances once every glyph row of the cell row is out.
              if (!w_grow_end) begin
                r_grow <= r_grow + 1'b1;
              end else begin
                r_grow      <= '0;
                r_line_base <= r_line_base + CONSOLE_DEPTH'(COLS);
                if (!w_crow_end) r_crow <= r_crow + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_frame_count <= r_frame_count + 16'd1;
          r_busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_char_rd     = (r_state == S_CHAR_RD);
  assign o_char_addr   = o_char_rd ? w_cell_addr : r_char_addr;
  assign o_font_rd     = (r_state == S_FONT_RD);
  assign o_font_addr   = o_font_rd ? w_font_addr : r_font_addr;
  assign o_axis_valid  = w_emit;
  assign o_axis_data   = !w_emit ? '0 : (w_pix ? FOREGROUND_COLOR : BACKGROUND_COLOR);
  assign o_axis_last   = w_emit && w_line_end && w_cell_end;
  assign o_axis_user   = {3'b000, w_emit && w_sof};
  assign o_busy        = r_busy;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_axi_osd_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected char/font addresses and pixel beats,
// a negedge monitor pops and compares whenever the DUT strobes or hands off a beat.
module tb_axi_osd_frame_sequencer;
  localparam int CD = 2, FW = 16, FH = 32, COLS = 2, ROWS = 2, GH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_enable = 1'b0;
  logic [1:0]  i_start_offset = '0;
  logic        i_cursor_en = 1'b0;
  logic [1:0]  i_cursor_addr = '0;
  logic        o_char_rd;
  logic [1:0]  o_char_addr;
  logic [7:0]  i_char_data = '0;
  logic        o_font_rd;
  logic [11:0] o_font_addr;
  logic [7:0]  i_font_data = '0;
  logic [23:0] o_axis_data;
  logic        o_axis_valid;
  logic        i_axis_ready = 1'b1;
  logic        o_axis_last;
  logic [3:0]  o_axis_user;
  logic        o_busy;
  logic [15:0] o_frame_count;

  axi_osd_frame_sequencer #(
    .CONSOLE_DEPTH(CD), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
    .FONT_WIDTH(8), .FONT_ROW_BITS(4), .PIXEL_WIDTH(24),
    .FOREGROUND_COLOR(24'hFFFFFF), .BACKGROUND_COLOR(24'h000000)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_start_offset(i_start_offset),
    .i_cursor_en(i_cursor_en), .i_cursor_addr(i_cursor_addr),
    .o_char_rd(o_char_rd), .o_char_addr(o_char_addr), .i_char_data(i_char_data),
    .o_font_rd(o_font_rd), .o_font_addr(o_font_addr), .i_font_data(i_font_data),
    .o_axis_data(o_axis_data), .o_axis_valid(o_axis_valid), .i_axis_ready(i_axis_ready),
    .o_axis_last(o_axis_last), .o_axis_user(o_axis_user), .o_busy(o_busy),
    .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic        user;
  } beat_t;

  beat_t       beat_q[$];
  logic [1:0]  char_q[$];
  logic [11:0] font_q[$];
  logic [7:0]  ram [4];
  bit          rom_mode = 1'b0;
  bit          rdy_rand = 1'b0;
  int          n_chk = 0, n_err = 0, beat_cnt = 0, exp_frames = 0;

  function automatic logic [7:0] rom_f(input logic [11:0] a);
    return rom_mode ? (a[7:0] ^ {a[11:8], a[11:8]}) : 8'hA5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_ram(input logic [7:0] a0, a1, a2, a3);
    ram[0] = a0; ram[1] = a1; ram[2] = a2; ram[3] = a3;
  endtask

  // Reference raster walk: cell rows, then glyph rows, then columns, MSB first.
  task automatic push_frame(input logic [1:0] off, input bit cen, input logic [1:0] cur);
    logic [1:0]  a;
    logic [11:0] fa;
    logic [7:0]  g;
    beat_t       b;
    for (int cr = 0; cr < ROWS; cr++)
      for (int gr = 0; gr < GH; gr++)
        for (int c = 0; c < COLS; c++) begin
          a  = 2'(int'(off) + cr * COLS + c);
          fa = {ram[a], 4'(gr)};
          g  = rom_f(fa);
          char_q.push_back(a);
          font_q.push_back(fa);
          for (int k = 7; k >= 0; k--) begin
            b.data = (g[k] ^ (cen && a == cur)) ? 24'hFFFFFF : 24'h000000;
            b.last = (c == COLS - 1) && (k == 0);
            b.user = (cr == 0) && (gr == 0) && (c == 0) && (k == 7);
            beat_q.push_back(b);
          end
        end
  endtask

  // Memory models: one-cycle read latency for console RAM and font ROM.
  initial begin
    logic       cr, fr;
    logic [1:0] ca;
    logic [11:0] fa;
    forever begin
      @(negedge clk);
      cr = o_char_rd; ca = o_char_addr; fr = o_font_rd; fa = o_font_addr;
      @(posedge clk); #1;
      if (cr) i_char_data = ram[ca];
      if (fr) i_font_data = rom_f(fa);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      i_axis_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor
  initial begin
    beat_t prev, e;
    bit    pv, pr;
    pv = 0; pr = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 0;
        continue;
      end
      if (pv && !pr) begin
        chk("stall_valid", 32'(o_axis_valid), 32'd1);
        chk("stall_hold", 32'({o_axis_data, o_axis_last, o_axis_user[0]}), 32'(prev));
      end
      if (o_char_rd) begin
        if (char_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL char_unexpected: addr %0h with nothing expected", o_char_addr);
        end else chk("char_addr", 32'(o_char_addr), 32'(char_q.pop_front()));
      end
      if (o_font_rd) begin
        if (font_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL font_unexpected: addr %0h with nothing expected", o_font_addr);
        end else chk("font_addr", 32'(o_font_addr), 32'(font_q.pop_front()));
      end
      if (o_axis_valid && i_axis_ready) begin
        beat_cnt++;
        if (beat_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL beat_unexpected: data %0h user %0h", o_axis_data, o_axis_user);
        end else begin
          e = beat_q.pop_front();
          chk("pix_data", 32'(o_axis_data), 32'(e.data));
          chk("pix_last", 32'(o_axis_last), 32'(e.last));
          chk("pix_user", 32'(o_axis_user), 32'({3'b000, e.user}));
        end
      end
      pv = o_axis_valid; pr = i_axis_ready;
      prev = {o_axis_data, o_axis_last, o_axis_user[0]};
    end
  end

  task automatic start_frame(input logic [1:0] off, input bit cen, input logic [1:0] cur);
    int t;
    @(posedge clk); #1;
    i_start_offset = off; i_cursor_en = cen; i_cursor_addr = cur;
    push_frame(off, cen, cur);
    beat_cnt = 0;
    i_enable = 1'b1;
    t = 0;
    while (!o_busy && t < 10) begin @(posedge clk); #1; t++; end
    chk("busy_rise", 32'(o_busy), 32'd1);
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (beat_cnt < n && t < 5000) begin @(posedge clk); #1; t++; end
    chk("beats_reached", 32'(beat_cnt >= n), 32'd1);
  endtask

  task automatic run_frame(input logic [1:0] off, input bit cen, input logic [1:0] cur,
                           input int drop_at);
    int t;
    start_frame(off, cen, cur);
    if (drop_at > 0) wait_beats(drop_at);
    i_enable = 1'b0;
    // Mid-frame changes must not affect the frame in flight.
    i_start_offset = ~off; i_cursor_en = ~cen; i_cursor_addr = ~cur;
    t = 0;
    while (o_busy && t < 6000) begin @(posedge clk); #1; t++; end
    chk("busy_fall", 32'(o_busy), 32'd0);
    exp_frames++;
    chk("frame_count", 32'(o_frame_count), 32'(exp_frames));
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after", 32'(o_busy), 32'd0);
    chk("beat_total", 32'(beat_cnt), 32'd512);
    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    chk("char_q_drained", 32'(char_q.size()), 32'd0);
    chk("font_q_drained", 32'(font_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    n_chk++; n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    set_ram(8'd0, 8'd1, 8'd2, 8'd3);
    rst = 1'b0; i_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_axis_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_frame_count", 32'(o_frame_count), 32'd0);
    chk("rst_char_rd", 32'(o_char_rd), 32'd0);
    chk("rst_font_rd", 32'(o_font_rd), 32'd0);
    chk("rst_last_user", 32'({o_axis_last, o_axis_user}), 32'd0);
    chk("rst_data", 32'(o_axis_data), 32'd0);
    i_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    run_frame(2'd0, 1'b0, 2'd0, 0);          // base frame
    rdy_rand = 1'b1;
    run_frame(2'd0, 1'b0, 2'd0, 0);          // backpressure
    rdy_rand = 1'b0;
    set_ram(8'h10, 8'h21, 8'h32, 8'h43);
    rom_mode = 1'b1;
    run_frame(2'd3, 1'b0, 2'd0, 0);          // address wrap, data-dependent glyphs
    set_ram(8'd0, 8'd1, 8'd2, 8'd3);
    rom_mode = 1'b0;
    run_frame(2'd0, 1'b1, 2'd1, 0);          // cursor on cell 1
    run_frame(2'd1, 1'b0, 2'd0, 100);        // enable dropped at beat 100

    // Reset mid-frame at beat 100.
    start_frame(2'd1, 1'b0, 2'd0);
    wait_beats(100);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_axis_valid), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_frame_count", 32'(o_frame_count), 32'd0);
    beat_q.delete(); char_q.delete(); font_q.delete();
    exp_frames = 0;
    @(posedge clk); #1;
    i_enable = 1'b0;
    rst = 1'b1;
    run_frame(2'd2, 1'b0, 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_osd_frame_sequencer.md
Name: axi_osd_frame_sequencer

Overview:
- Raster controller that drives the on-screen-display render path for one full video frame.
- Walks every pixel of the frame in raster order and reads the character code for each cell from the console character RAM.
- Looks up the glyph row for that code in the font ROM and emits foreground/background pixels on an AXI-Stream master.
- Marks the first pixel of each frame with TUSER[0] and the last pixel of each line with TLAST; these feed the video output stage.

Parameters:
- CONSOLE_DEPTH, 12, address width of the console character RAM (2^CONSOLE_DEPTH cells).
- FRAME_WIDTH, 640, pixels per line; must be a multiple of FONT_WIDTH.
- FRAME_HEIGHT, 480, lines per frame; must be a multiple of 2^FONT_ROW_BITS.
- FONT_WIDTH, 8, glyph width in pixels (bits per font word).
- FONT_ROW_BITS, 4, log2 of glyph height (glyph height 16).
- PIXEL_WIDTH, 24, AXIS pixel width.
- FOREGROUND_COLOR, 24'hFFFFFF, pixel value for a glyph bit of 1.
- BACKGROUND_COLOR, 24'h000000, pixel value for a glyph bit of 0.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  start and continue frames while high.
- i_start_offset  in  CONSOLE_DEPTH  console address of the top-left cell (scroll base); sampled at frame start.
- i_cursor_en  in  1  enable cursor inversion; sampled at frame start.
- i_cursor_addr  in  CONSOLE_DEPTH  console address of the cursor cell; sampled at frame start.
- o_char_rd  out  1  console RAM read strobe.
- o_char_addr  out  CONSOLE_DEPTH  console RAM address.
- i_char_data  in  8  character code; valid the cycle after o_char_rd.
- o_font_rd  out  1  font ROM read strobe.
- o_font_addr  out  8+FONT_ROW_BITS  font address {char_code, glyph_row}.
- i_font_data  in  FONT_WIDTH  glyph row bits; valid the cycle after o_font_rd.
- o_axis_data  out  PIXEL_WIDTH  pixel.
- o_axis_valid  out  1  AXIS valid.
- i_axis_ready  in  1  AXIS ready.
- o_axis_last  out  1  last pixel of line.
- o_axis_user  out  4  bit0 = start of frame; bits 3:1 tied to 0.
- o_busy  out  1  frame in progress.
- o_frame_count  out  16  completed frames; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, counters cleared.
- Geometry: COLS = FRAME_WIDTH/FONT_WIDTH; ROWS = FRAME_HEIGHT >> FONT_ROW_BITS.
- Cell address = (start_offset + cell_row*COLS + col) mod 2^CONSOLE_DEPTH.
  - Implement with an incrementing line_base register and a column adder; no multiplier.
  - Wrap is natural truncation to CONSOLE_DEPTH bits.
- The address for a cell is recomputed on every glyph row of that cell.
- States:
  - IDLE: if i_enable, latch offset/cursor, clear x/y, set o_busy=1 -> CHAR_RD.
  - CHAR_RD (1 cycle): o_char_rd=1, o_char_addr = cell address -> FONT_RD.
  - FONT_RD (1 cycle): o_font_rd=1, o_font_addr = {i_char_data, glyph_row}; record cursor hit (i_cursor_en && cell address == cursor) -> LOAD.
  - LOAD (1 cycle): register i_font_data into the shift register -> EMIT.
  - EMIT: o_axis_valid=1; pixel = FOREGROUND_COLOR if the current bit is 1, else BACKGROUND_COLOR. Colours are swapped on a cursor hit. MSB (bit FONT_WIDTH-1) is the leftmost pixel.
    - Advance only on valid&&ready; data/last/user stay stable while stalled.
    - After FONT_WIDTH accepted beats: next cell -> CHAR_RD; or, if last beat of the frame -> DONE.
  - DONE (1 cycle): o_frame_count += 1, o_busy=0 -> IDLE.
- o_axis_user[0]=1 only on beat (0,0); o_axis_last=1 only on pixel x=FRAME_WIDTH-1.
- Valid drops in CHAR_RD/FONT_RD/LOAD (3-cycle bubble per cell); this is a legal AXIS gap.
- Strobes o_char_rd/o_font_rd are single-cycle pulses; their addresses hold their last values otherwise.
- Deasserting i_enable mid-frame has no effect until DONE; the current frame always completes. Re-asserting during DONE starts the next frame from IDLE on the following cycle.
- Offset/cursor changes mid-frame are ignored until the next frame start.
- Reset mid-frame: valid drops asynchronously; the next frame restarts at (0,0) with user[0]=1.

Test Plan:
- Reset: hold rst=0 with i_enable=1 -> o_axis_valid=0, o_busy=0, o_frame_count=0, strobes 0.
- Base frame: FRAME_WIDTH=16, FRAME_HEIGHT=32, FONT 8x16, offset 0; RAM[k]=k; ROM word 8'hA5; ready=1.
  - Required: 512 beats; beat0 user=1; pixels FF..,00..,FF..,00..,00..,FF..,00..,FF.. repeating.
  - Required: last on every 16th beat; char addresses 0,1 (×16 rows), then 2,3; o_frame_count=1.
- Backpressure: random i_axis_ready 50% -> data/last/user held constant across stalls; still 512 beats; pixel sequence identical to the base frame.
- Wrap: CONSOLE_DEPTH=2, offset=3 -> row0 addresses 3,0; row1 addresses 1,2; o_font_addr = {RAM[addr], glyph_row}.
- Cursor: i_cursor_en=1, cursor_addr=1 -> pixels of cell 1 inverted (00 where FF) on all 16 glyph rows; cell 0 unchanged.
- Enable/reset: drop i_enable at beat 100 -> frame completes (512 beats), no further user[0]. Pull rst low at beat 100 of a new frame -> valid=0 same cycle; after release, next beat has user[0]=1 and address = offset.
